// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: 128KB RAM plus memory-mapped UART TX/RX,
// free-running cycle counter and a sticky program-stop flag.
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TXQ_LOG2    = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends on ready. The CPU bus has no strobe: every cycle is a bus cycle.

  localparam int DEPTH = 2 ** TXQ_LOG2;
  localparam int CW    = TXQ_LOG2 + 1;

  logic [7:0] ram [2**RAM_AW];
  logic [7:0] txq [DEPTH];

  logic [7:0]          ram_rdata_q;
  logic                rd_ram_q;
  logic [7:0]          io_rdata_q;
  logic [31:0]         cnt_q;
  logic [31:0]         snap_q;
  logic                rx_full_q;
  logic [7:0]          rx_byte_q;
  logic [TXQ_LOG2-1:0] wr_ptr_q;
  logic [TXQ_LOG2-1:0] rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                prog_stop_q;
  logic                tx_overflow_q;

  logic              sel_io;
  logic              sel_ram;
  logic              rd;
  logic              io_data;
  logic              io_cnt;
  logic              io_stop;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        io_rd_byte;
  logic              rx_pop;
  logic              rx_load;
  logic              tx_push;
  logic              tx_push_ok;
  logic [7:0]        tx_push_byte;
  logic              tx_pop;
  logic              tx_full;
  logic              unused_addr;

  assign sel_io      = (bus_a[17:16] == 2'b11);
  assign sel_ram     = ~bus_a[17];
  assign rd          = ~bus_wr;
  assign io_data     = sel_io && (bus_a[15:0] == 16'h0000);
  assign io_cnt      = sel_io && (bus_a[15:2] == 14'd1);
  assign io_stop     = sel_io && (bus_a[15:0] == 16'h0004);
  assign ram_addr    = bus_a[RAM_AW-1:0];
  assign unused_addr = ^bus_a[31:18];

  // Counter offsets: only byte 0 is live; its read freezes the whole word for bytes 1..3.
  always_comb begin
    io_rd_byte = 8'h00;
    if (io_data) begin
      io_rd_byte = rx_full_q ? rx_byte_q : 8'h00;
    end else if (io_cnt) begin
      case (bus_a[1:0])
        2'd0:    io_rd_byte = cnt_q[7:0];
        2'd1:    io_rd_byte = snap_q[15:8];
        2'd2:    io_rd_byte = snap_q[23:16];
        default: io_rd_byte = snap_q[31:24];
      endcase
    end
  end

  assign rx_pop       = rd && io_data;
  assign rx_load      = rx_valid && ~rx_full_q;
  assign rx_ready     = ~rx_full_q;

  assign tx_valid     = (count_q != '0);
  assign tx_data      = txq[rd_ptr_q];
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_full      = (count_q == CW'(DEPTH));
  // A zero byte can only be queued through the stop port.
  assign tx_push      = bus_wr && ((io_data && (bus_wdata != 8'h00)) || io_stop);
  assign tx_push_byte = io_stop ? 8'h00 : bus_wdata;
  assign tx_push_ok   = tx_push && (~tx_full || tx_pop);
  assign count_d      = count_q + CW'(tx_push_ok) - CW'(tx_pop);

  assign io_buffer_full = ((CW'(DEPTH) - count_q) <= CW'(FULL_MARGIN));
  assign bus_rdata      = rd_ram_q ? ram_rdata_q : io_rdata_q;
  assign prog_stop      = prog_stop_q;
  assign tx_overflow    = tx_overflow_q;

  // RAM kept free of reset so it maps onto block memory.
  always_ff @(posedge clk_in) begin
    if (bus_wr && sel_ram) ram[ram_addr] <= bus_wdata;
    if (rd && sel_ram)     ram_rdata_q   <= ram[ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (tx_push_ok) txq[wr_ptr_q] <= tx_push_byte;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_ram_q      <= 1'b0;
      io_rdata_q    <= 8'h00;
      cnt_q         <= 32'd0;
      snap_q        <= 32'd0;
      rx_full_q     <= 1'b0;
      rx_byte_q     <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      prog_stop_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (rd) begin
        rd_ram_q <= sel_ram;
        if (!sel_ram) io_rdata_q <= io_rd_byte;
      end
      if (rd && io_cnt && (bus_a[1:0] == 2'd0)) snap_q <= cnt_q;
      if (rx_load) begin
        rx_full_q <= 1'b1;
        rx_byte_q <= rx_data;
      end else if (rx_pop) begin
        rx_full_q <= 1'b0;
      end
      if (tx_push_ok) wr_ptr_q <= wr_ptr_q + TXQ_LOG2'(1);
      if (tx_pop)     rd_ptr_q <= rd_ptr_q + TXQ_LOG2'(1);
      count_q <= count_d;
      if (bus_wr && io_stop)      prog_stop_q   <= 1'b1;
      if (tx_push && !tx_push_ok) tx_overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios, then random bus/UART traffic,
// all checked against a queue-based reference model of the bus map.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in(clk), .rst_in(rst_n), .bus_a(bus_a), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  // Reference model state
  logic [7:0]  ram_m [int unsigned];
  logic [7:0]  exp_q [$];
  logic        rx_full_m;
  logic [7:0]  rx_byte_m;
  logic [31:0] cnt_m;
  logic [31:0] snap_m;
  logic [7:0]  rdata_m;
  bit          rdata_known;
  logic        stop_m;
  logic        ovf_m;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the bus map rules to the inputs present at the coming edge.
  task automatic model_edge();
    logic [17:0] a;
    logic [15:0] off;
    bit s_io, s_ram, load, pop, push;
    logic [7:0] push_byte;
    if (!rst_n) begin
      exp_q.delete();
      rx_full_m = 0; rx_byte_m = 0; cnt_m = 0; snap_m = 0;
      rdata_m = 0; rdata_known = 1; stop_m = 0; ovf_m = 0;
      return;
    end
    a = bus_a[17:0];
    off = a[15:0];
    s_io = (a[17:16] == 2'b11);
    s_ram = (a[17] == 1'b0);
    load = rx_valid && !rx_full_m;
    pop = tx_ready && (exp_q.size() != 0);
    push = 0;
    push_byte = 8'h00;
    if (!bus_wr) begin
      if (s_ram) begin
        rdata_known = ram_m.exists(int'(a[16:0]));
        if (rdata_known) rdata_m = ram_m[int'(a[16:0])];
      end else begin
        rdata_known = 1;
        rdata_m = 8'h00;
        if (s_io && off == 16'h0000) begin
          rdata_m = rx_full_m ? rx_byte_m : 8'h00;
          rx_full_m = 0;
        end else if (s_io && off >= 16'h0004 && off <= 16'h0007) begin
          if (off == 16'h0004) begin
            rdata_m = cnt_m[7:0];
            snap_m = cnt_m;
          end else begin
            rdata_m = snap_m[8*(off-4) +: 8];
          end
        end
      end
    end else begin
      if (s_ram) ram_m[int'(a[16:0])] = bus_wdata;
      if (s_io && off == 16'h0000 && bus_wdata != 8'h00) begin
        push = 1; push_byte = bus_wdata;
      end
      if (s_io && off == 16'h0004) begin
        push = 1; push_byte = 8'h00; stop_m = 1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < 16) exp_q.push_back(push_byte);
      else ovf_m = 1;
    end
    if (load) begin
      rx_full_m = 1;
      rx_byte_m = rx_data;
    end
    cnt_m = cnt_m + 32'd1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (rdata_known) check_eq("rdata", bus_rdata, rdata_m);
    check_eq("tx_valid", tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check_eq("tx_data", tx_data, exp_q[0]);
    check_eq("rx_ready", rx_ready, !rx_full_m);
    check_eq("io_full", io_buffer_full, (16 - exp_q.size()) <= 2);
    check_eq("prog_stop", prog_stop, stop_m);
    check_eq("tx_overflow", tx_overflow, ovf_m);
  endtask

  task automatic idle();
    bus_a = 32'h0002_0000; bus_wr = 0; bus_wdata = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus_a = a; bus_wr = 1; bus_wdata = d;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus_a = a; bus_wr = 0; bus_wdata = 8'h00;
    tick();
  endtask

  initial begin
    rst_n = 0; tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    idle();
    repeat (3) tick();
    check_eq("rst_rdata", bus_rdata, 8'h00);
    check_eq("rst_rx_ready", rx_ready, 1'b1);
    rst_n = 1;

    // Counter bytes read on cycles 100..103 give snapshot value 100
    for (int i = 0; i < 200 && cnt_m != 32'd100; i++) tick();
    check_eq("cnt_reach", cnt_m, 32'd100);
    bus_read(32'h0003_0004); check_eq("cnt_b0", bus_rdata, 8'h64);
    bus_read(32'h0003_0005); check_eq("cnt_b1", bus_rdata, 8'h00);
    bus_read(32'h0003_0006); check_eq("cnt_b2", bus_rdata, 8'h00);
    bus_read(32'h0003_0007); check_eq("cnt_b3", bus_rdata, 8'h00);

    // RAM with one-cycle read latency
    bus_write(32'h0000_0000, 8'h3C);
    bus_write(32'h0000_0010, 8'hA5);
    bus_read(32'h0002_0000);
    bus_a = 32'h0000_0010; bus_wr = 0;
    #1 check_eq("ram_same_cycle", bus_rdata, 8'h00);
    tick();
    check_eq("ram_rd", bus_rdata, 8'hA5);
    bus_write(32'h0001_FFFF, 8'h5A);
    bus_read(32'h0001_FFFF); check_eq("ram_top", bus_rdata, 8'h5A);

    // Unmapped space
    bus_write(32'h0002_0000, 8'h55);
    bus_read(32'h0002_0000); check_eq("unmap_rd", bus_rdata, 8'h00);
    bus_read(32'h0000_0000); check_eq("ram0_kept", bus_rdata, 8'h3C);

    // TX fill, near-full flag, overflow, zero-byte write ignored, then drain
    for (int i = 1; i <= 17; i++) begin
      bus_write(32'h0003_0000, 8'h41);
      if (i == 13) check_eq("iofull_13", io_buffer_full, 1'b0);
      if (i == 14) check_eq("iofull_14", io_buffer_full, 1'b1);
      if (i == 16) check_eq("ovf_16", tx_overflow, 1'b0);
    end
    check_eq("ovf_17", tx_overflow, 1'b1);
    bus_write(32'h0003_0000, 8'h00);
    idle();
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", tx_valid, 1'b1);
      check_eq("drain_byte", tx_data, 8'h41);
      tick();
    end
    check_eq("drain_empty", tx_valid, 1'b0);
    tx_ready = 0;

    // RX holding register
    rx_valid = 1; rx_data = 8'h7E;
    tick();
    rx_valid = 0; rx_data = 8'h00;
    check_eq("rx_busy", rx_ready, 1'b0);
    bus_read(32'h0003_0000);
    check_eq("rx_byte", bus_rdata, 8'h7E);
    check_eq("rx_free", rx_ready, 1'b1);
    bus_read(32'h0003_0000);
    check_eq("rx_empty", bus_rdata, 8'h00);

    // Stop port queues a zero byte
    bus_write(32'h0003_0004, 8'hFF);
    check_eq("stop_set", prog_stop, 1'b1);
    check_eq("stop_txv", tx_valid, 1'b1);
    check_eq("stop_txd", tx_data, 8'h00);

    // Counter wrap from all-ones
    idle();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    bus_read(32'h0003_0004); check_eq("wrap_ff", bus_rdata, 8'hFF);
    bus_read(32'h0003_0004); check_eq("wrap_zero", bus_rdata, 8'h00);
    bus_read(32'h0003_0007); check_eq("wrap_snap", bus_rdata, 8'h00);

    // Reset mid-operation
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    check_eq("rst2_rdata", bus_rdata, 8'h00);
    check_eq("rst2_txv", tx_valid, 1'b0);
    check_eq("rst2_stop", prog_stop, 1'b0);
    check_eq("rst2_ovf", tx_overflow, 1'b0);
    check_eq("rst2_full", io_buffer_full, 1'b0);
    check_eq("rst2_rxr", rx_ready, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0, 1:    a = 32'h0000_0000 + $urandom_range(0, 15);
        2:       a = 32'h0001_FFF0 + $urandom_range(0, 15);
        3:       a = 32'h0002_0000 + $urandom_range(0, 32'h1_FFFF);
        4:       a = 32'h0003_0000;
        5:       a = 32'h0003_0004 + $urandom_range(0, 3);
        6:       a = 32'h0003_0000 + $urandom_range(8, 16'hFFFF);
        default: a = 32'h0003_0000 + $urandom_range(0, 7);
      endcase
      a[31:18] = 14'($urandom);
      bus_a = a;
      bus_wr = ($urandom_range(0, 2) == 0);
      if (bus_wr && a[17:0] == 18'h30004 && $urandom_range(0, 3) != 0) bus_wr = 0;
      bus_wdata = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tx_ready = (i < 700) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = $urandom_range(0, 1);
      rx_data = 8'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
